// File: rtl/detector_secuencia_if.sv
// Digit-stream bus between a 4-bit digit source and the sequence detector.
// The source drives the qualified digit; the detector returns status pulses, progress and match count.
interface detector_secuencia_if #(
  parameter int CNT_W = 8
);
  logic             dig_valid;
  logic [3:0]       dig;
  logic             match;
  logic             trunc;
  logic             err;
  logic [3:0]       progress;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output dig_valid, dig,
    input  match, trunc, err, progress, match_cnt
  );

  modport slave (
    input  dig_valid, dig,
    output match, trunc, err, progress, match_cnt
  );
endinterface

// File: rtl/detector_secuencia.sv
// Tracks the digit sequence 2,1,5,5,0,0,7,9,4 and reports full matches, early-exit truncations
// and mismatches as one-cycle registered pulses, plus a saturating match counter.
module detector_secuencia #(
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  detector_secuencia_if.slave bus
);

  localparam logic [3:0] LAST_P = 4'd8;

  function automatic logic [3:0] exp_digit(input logic [3:0] p);
    case (p)
      4'd0:    exp_digit = 4'd2;
      4'd1:    exp_digit = 4'd1;
      4'd2:    exp_digit = 4'd5;
      4'd3:    exp_digit = 4'd5;
      4'd4:    exp_digit = 4'd0;
      4'd5:    exp_digit = 4'd0;
      4'd6:    exp_digit = 4'd7;
      4'd7:    exp_digit = 4'd9;
      default: exp_digit = 4'd4;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [3:0]       r_progress;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_match;
  logic             r_trunc;
  logic             r_err;
  logic [3:0]       w_exp;
  logic             w_started;

  assign w_exp     = exp_digit(r_progress);
  assign w_started = (r_progress != 4'd0);

  // At p==8 the expected digit is 4, so the trunc branch only ever sees p in 1..7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_progress  <= 4'd0;
      r_match_cnt <= '0;
      r_match     <= 1'b0;
      r_trunc     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_match <= 1'b0;
      r_trunc <= 1'b0;
      r_err   <= 1'b0;
      if (bus.dig_valid) begin
        if (bus.dig == w_exp) begin
          if (r_progress == LAST_P) begin
            r_match     <= 1'b1;
            r_progress  <= 4'd0;
            r_match_cnt <= sat_inc(r_match_cnt);
          end else begin
            r_progress <= r_progress + 4'd1;
          end
        end else if (bus.dig == 4'd4 && w_started) begin
          r_trunc    <= 1'b1;
          r_progress <= 4'd0;
        end else if (bus.dig == 4'd2) begin
          r_err      <= w_started;
          r_progress <= 4'd1;
        end else begin
          r_err      <= w_started;
          r_progress <= 4'd0;
        end
      end
    end
  end

  assign bus.match     = r_match;
  assign bus.trunc     = r_trunc;
  assign bus.err       = r_err;
  assign bus.progress  = r_progress;
  assign bus.match_cnt = r_match_cnt;

endmodule

// File: tb/tb_detector_secuencia.sv
// Directed bench for detector_secuencia: one 8-bit-counter instance and one 2-bit-counter
// instance share the same digit stream.
module tb_detector_secuencia;

  logic clk;
  logic rst;

  detector_secuencia_if #(.CNT_W(8)) bus8 ();
  detector_secuencia_if #(.CNT_W(2)) bus2 ();

  detector_secuencia #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  detector_secuencia #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_chk  = 0;
  int n_pass = 0;
  int seq [9] = '{2, 1, 5, 5, 0, 0, 7, 9, 4};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
  endtask

  task automatic drive(input logic v, input logic [3:0] d);
    @(negedge clk);
    bus8.dig_valid = v;
    bus8.dig       = d;
    bus2.dig_valid = v;
    bus2.dig       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input int m, input int t, input int e);
    chk({tag, " match"}, int'(bus8.match), m);
    chk({tag, " trunc"}, int'(bus8.trunc), t);
    chk({tag, " err"},   int'(bus8.err),   e);
  endtask

  task automatic run_seq(input string tag);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'(seq[i]));
      chk({tag, " progress"}, int'(bus8.progress), (i == 8) ? 0 : i + 1);
      chk_pulses(tag, (i == 8) ? 1 : 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.dig_valid = 1'b0; bus8.dig = 4'd0;
    bus2.dig_valid = 1'b0; bus2.dig = 4'd0;
    #12;
    chk("rst progress", int'(bus8.progress), 0);
    chk("rst cnt", int'(bus8.match_cnt), 0);
    chk_pulses("rst", 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    // Clean match
    run_seq("clean");
    chk("clean cnt8", int'(bus8.match_cnt), 1);
    chk("clean cnt2", int'(bus2.match_cnt), 1);
    drive(1'b0, 4'd2);
    chk_pulses("clean after", 0, 0, 0);

    // Truncated with gaps; dig=2 while invalid must be ignored
    drive(1'b1, 4'd2); chk("tr p1", int'(bus8.progress), 1);
    drive(1'b0, 4'd2); chk("tr gap1", int'(bus8.progress), 1);
    drive(1'b1, 4'd1); chk("tr p2", int'(bus8.progress), 2);
    drive(1'b0, 4'd4); chk("tr gap2", int'(bus8.progress), 2);
    drive(1'b1, 4'd5); chk("tr p3", int'(bus8.progress), 3);
    drive(1'b0, 4'd4); chk("tr gap3", int'(bus8.progress), 3);
    drive(1'b1, 4'd4); chk("tr p0", int'(bus8.progress), 0);
    chk_pulses("tr", 0, 1, 0);
    drive(1'b0, 4'd0); chk_pulses("tr clear", 0, 0, 0);
    chk("tr cnt", int'(bus8.match_cnt), 1);

    // Mismatch and restart
    drive(1'b1, 4'd2);
    drive(1'b1, 4'd1);
    drive(1'b1, 4'd2);
    chk_pulses("mm", 0, 0, 1);
    chk("mm progress", int'(bus8.progress), 1);
    for (int i = 1; i < 9; i++) begin
      drive(1'b1, 4'(seq[i]));
      chk("mm2 progress", int'(bus8.progress), (i == 8) ? 0 : i + 1);
    end
    chk_pulses("mm end", 1, 0, 0);
    chk("mm cnt8", int'(bus8.match_cnt), 2);
    chk("mm cnt2", int'(bus2.match_cnt), 2);

    // Idle digits at p=0, then 2,8
    drive(1'b1, 4'd4);  chk_pulses("idle4", 0, 0, 0);  chk("idle4 p", int'(bus8.progress), 0);
    drive(1'b1, 4'd7);  chk_pulses("idle7", 0, 0, 0);  chk("idle7 p", int'(bus8.progress), 0);
    drive(1'b1, 4'd15); chk_pulses("idle15", 0, 0, 0); chk("idle15 p", int'(bus8.progress), 0);
    drive(1'b1, 4'd2);  chk("idle2 p", int'(bus8.progress), 1);
    drive(1'b1, 4'd8);  chk_pulses("idle8", 0, 0, 1);  chk("idle8 p", int'(bus8.progress), 0);

    // Saturation from a clean reset
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("sat rst cnt2", int'(bus2.match_cnt), 0);
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 9; i++) drive(1'b1, 4'(seq[i]));
      chk("sat match2", int'(bus2.match), 1);
      chk("sat cnt2", int'(bus2.match_cnt), (k < 3) ? k : 3);
      chk("sat cnt8", int'(bus8.match_cnt), k);
    end

    // Async reset mid-sequence
    for (int i = 0; i < 5; i++) drive(1'b1, 4'(seq[i]));
    chk("mid p5", int'(bus8.progress), 5);
    #2 rst = 1'b1;
    #1;
    chk("mid rst p", int'(bus8.progress), 0);
    chk("mid rst cnt", int'(bus8.match_cnt), 0);
    chk_pulses("mid rst", 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    run_seq("post");
    chk("post cnt", int'(bus8.match_cnt), 1);

    // Async reset clears a pending match pulse
    #2 rst = 1'b1;
    #1;
    chk("pend match", int'(bus8.match), 0);
    chk("pend cnt", int'(bus8.match_cnt), 0);
    @(negedge clk) rst = 1'b0;
    drive(1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
